hostbus_bridge: RTL and testbench

HOSTBUS_BRIDGE -- requirements
Module: hostbus_bridge

---
 rtl/hostbus_bridge.sv | 257 +++++++++++++++++++++++++
 tb/tb_hostbus_bridge.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hostbus_bridge.sv
// hostbus_bridge
//   Bridges an asynchronous 8-bit host strobe bus (nrd/nwr/ncs) onto a 16-bit
//   internal request/acknowledge bus. Host writes are posted through a FIFO.
//   Host reads are issued as RDCMD commands and are ordered behind any queued
//   writes. A vsync pulse and a "FIFO drained" event can raise int_sig.
// Ports
//   clk, nrst                  system clock, asynchronous active-low reset
//   nrd, nwr, ncs              asynchronous active-low host strobes
//   ext_address, ext_data_in   host register select and write data
//   ext_data_out               registered host read data
//   wait_sig                   host stall (full FIFO, or RDATA read while a read is outstanding)
//   int_sig                    registered interrupt
//   vsync_in                   frame pulse, synchronous to clk
//   int_req, int_we            internal request and write qualifier
//   int_address, int_data_out  internal address and write data
//   int_ack, int_data_in       one-cycle completion and read data
module hostbus_bridge #(
  parameter int EXT_AW      = 4,
  parameter int INT_AW      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              nrd,
  input  logic              nwr,
  input  logic              ncs,
  input  logic [EXT_AW-1:0] ext_address,
  input  logic [7:0]        ext_data_in,
  output logic [7:0]        ext_data_out,
  output logic              wait_sig,
  output logic              int_sig,
  input  logic              vsync_in,
  output logic              int_req,
  output logic              int_we,
  output logic [INT_AW-1:0] int_address,
  output logic [15:0]       int_data_out,
  input  logic              int_ack,
  input  logic [15:0]       int_data_in
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [31:0] REG_ADDR_LO  = 32'd0;
  localparam logic [31:0] REG_ADDR_HI  = 32'd1;
  localparam logic [31:0] REG_DATA_LO  = 32'd2;
  localparam logic [31:0] REG_DATA_HI  = 32'd3;
  localparam logic [31:0] REG_CTRL     = 32'd4;
  localparam logic [31:0] REG_STATUS   = 32'd5;
  localparam logic [31:0] REG_RDCMD    = 32'd6;
  localparam logic [31:0] REG_RDATA_LO = 32'd7;
  localparam logic [31:0] REG_RDATA_HI = 32'd8;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  typedef struct packed {
    logic [INT_AW-1:0] addr;
    logic [15:0]       data;
  } entry_t;

  // ---------------- strobe synchronisers and edge detection ----------------
  logic [SYNC_STAGES-1:0] nrd_sync, nwr_sync, ncs_sync;
  logic wr_n_q, rd_n_q;
  logic ncs_s, wr_n, rd_n, wr_evt, rd_evt;

  // NOTE: every clocked process uses non-blocking assignments so all flops
  // sample the same pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nrd_sync <= '1;
      nwr_sync <= '1;
      ncs_sync <= '1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
    end else begin
      nrd_sync <= {nrd_sync[SYNC_STAGES-2:0], nrd};
      nwr_sync <= {nwr_sync[SYNC_STAGES-2:0], nwr};
      ncs_sync <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      wr_n_q   <= wr_n;
      rd_n_q   <= rd_n;
    end
  end

  assign ncs_s  = ncs_sync[SYNC_STAGES-1];
  assign wr_n   = ncs_s | nwr_sync[SYNC_STAGES-1];
  assign rd_n   = ncs_s | nrd_sync[SYNC_STAGES-1];
  assign wr_evt = wr_n_q & ~wr_n;
  assign rd_evt = rd_n_q & ~rd_n;

  logic [31:0] sel;
  assign sel = 32'(ext_address);

  // ---------------- register state ----------------
  logic [INT_AW-1:0] addr, rd_addr, rd_req_addr;
  logic [15:0]       addr16, rdata;
  logic [7:0]        data_lo, ctrl, hold_hi, rd_mux, status;
  logic              hold_wr, hold_rd, hold_sel_hi;
  logic              rd_pend, rd_valid, vs_pend, dr_pend, vsync_q;
  state_t            state, state_next;

  // ---------------- write FIFO ----------------
  entry_t            mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       count;
  logic              full, empty, push, pop, drain, rd_done;
  entry_t            head;

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // A DATA_HI write that meets a full FIFO is held until a slot frees up.
  logic wr_hi_req, rd_78_evt, rd_78_req, serve_78, cur_sel_hi;
  logic [7:0] push_hi;
  assign wr_hi_req  = (wr_evt && sel == REG_DATA_HI) || hold_wr;
  assign push       = wr_hi_req & ~full;
  assign push_hi    = hold_wr ? hold_hi : ext_data_in;
  assign pop        = (state == S_WRITE) & int_ack;
  assign rd_done    = (state == S_READ) & int_ack;
  assign drain      = pop & ~push & (count == (PW+1)'(1));

  // RDATA reads are held while a read command is still outstanding.
  assign rd_78_evt  = rd_evt && (sel == REG_RDATA_LO || sel == REG_RDATA_HI);
  assign rd_78_req  = rd_78_evt | hold_rd;
  assign serve_78   = rd_78_req & ~rd_pend;
  assign cur_sel_hi = hold_rd ? hold_sel_hi : (sel == REG_RDATA_HI);

  assign wait_sig = ~ncs_s & ((wr_hi_req & full) | (rd_78_req & rd_pend));

  // NOTE: the FIFO storage carries no reset; validity is tracked solely by
  // the pointers and count, which are reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{addr: addr, data: {push_hi, data_lo}};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // ---------------- host register file ----------------
  assign addr16 = 16'(addr);
  assign status = {3'b000, rd_valid, dr_pend, vs_pend, full, empty};

  // NOTE: defaults first so every path assigns rd_mux and no latch is inferred.
  always_comb begin
    rd_mux = 8'h00;
    case (sel)
      REG_ADDR_LO:  rd_mux = addr16[7:0];
      REG_ADDR_HI:  rd_mux = addr16[15:8];
      REG_DATA_LO:  rd_mux = data_lo;
      REG_CTRL:     rd_mux = ctrl;
      REG_STATUS:   rd_mux = status;
      REG_RDATA_LO: rd_mux = rdata[7:0];
      REG_RDATA_HI: rd_mux = rdata[15:8];
      default:      rd_mux = 8'h00;
    endcase
  end

  logic rdcmd, status_wr;
  assign rdcmd     = wr_evt && sel == REG_RDCMD;
  assign status_wr = wr_evt && sel == REG_STATUS;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr         <= '0;
      data_lo      <= '0;
      ctrl         <= '0;
      hold_wr      <= 1'b0;
      hold_hi      <= '0;
      hold_rd      <= 1'b0;
      hold_sel_hi  <= 1'b0;
      rd_pend      <= 1'b0;
      rd_valid     <= 1'b0;
      rd_addr      <= '0;
      rd_req_addr  <= '0;
      rdata        <= '0;
      vs_pend      <= 1'b0;
      dr_pend      <= 1'b0;
      vsync_q      <= 1'b0;
      int_sig      <= 1'b0;
      ext_data_out <= '0;
      state        <= S_IDLE;
    end else begin
      state   <= state_next;
      vsync_q <= vsync_in;

      if (wr_evt && sel == REG_ADDR_LO)
        addr <= INT_AW'({addr16[15:8], ext_data_in});
      else if (wr_evt && sel == REG_ADDR_HI)
        addr <= INT_AW'({ext_data_in, addr16[7:0]});
      else
        addr <= addr + INT_AW'(push ? ctrl[7:4] : 4'd0)
                     + INT_AW'(rd_done ? ctrl[7:4] : 4'd0);

      if (wr_evt && sel == REG_DATA_LO) data_lo <= ext_data_in;
      if (wr_evt && sel == REG_CTRL)    ctrl    <= ext_data_in;
      if (wr_evt && sel == REG_DATA_HI) hold_hi <= ext_data_in;
      hold_wr <= wr_hi_req & full;

      // A new RDCMD overrides completion of an older one in the same cycle.
      rd_pend  <= rdcmd | (rd_pend & ~rd_done);
      rd_valid <= ~rdcmd & (rd_done | rd_valid);
      if (rdcmd)   rd_addr <= addr;
      if (rd_done) rdata   <= int_data_in;
      if (state == S_IDLE && state_next == S_READ) rd_req_addr <= rd_addr;

      // Set beats a simultaneous clear.
      vs_pend <= (vsync_in & ~vsync_q) | (vs_pend & ~(status_wr & ext_data_in[2]));
      dr_pend <= drain | (dr_pend & ~(status_wr & ext_data_in[3]));
      int_sig <= (vs_pend & ctrl[0]) | (dr_pend & ctrl[1]);

      hold_rd <= rd_78_req & rd_pend;
      if (rd_78_evt) hold_sel_hi <= (sel == REG_RDATA_HI);
      if (rd_evt && !rd_78_evt)
        ext_data_out <= rd_mux;
      else if (serve_78)
        ext_data_out <= cur_sel_hi ? rdata[15:8] : rdata[7:0];
    end
  end

  // ---------------- internal bus FSM ----------------
  always_comb begin
    state_next   = state;
    int_req      = 1'b0;
    int_we       = 1'b0;
    int_address  = '0;
    int_data_out = '0;
    case (state)
      S_IDLE: begin
        if (!empty)       state_next = S_WRITE;
        else if (rd_pend) state_next = S_READ;
      end
      S_WRITE: begin
        int_req      = 1'b1;
        int_we       = 1'b1;
        int_address  = head.addr;
        int_data_out = head.data;
        if (int_ack) state_next = S_IDLE;
      end
      S_READ: begin
        int_req     = 1'b1;
        int_address = rd_req_addr;
        if (int_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hostbus_bridge.sv
// tb_hostbus_bridge
//   Directed bench for hostbus_bridge with default parameters. Expected
//   internal-bus transactions and host read values are queued as stimulus is
//   issued; independent monitor processes pop and compare them.
module tb_hostbus_bridge;

  localparam int SYNC_STAGES = 2;
  localparam int FIFO_DEPTH  = 8;

  logic        clk = 1'b0;
  logic        nrst;
  logic        nrd, nwr, ncs;
  logic [3:0]  ext_address;
  logic [7:0]  ext_data_in;
  logic [7:0]  ext_data_out;
  logic        wait_sig, int_sig, vsync_in;
  logic        int_req, int_we;
  logic [15:0] int_address, int_data_out;
  logic        int_ack;
  logic [15:0] int_data_in;

  hostbus_bridge #(
    .EXT_AW(4), .INT_AW(16), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .nrst(nrst), .nrd(nrd), .nwr(nwr), .ncs(ncs),
    .ext_address(ext_address), .ext_data_in(ext_data_in),
    .ext_data_out(ext_data_out), .wait_sig(wait_sig), .int_sig(int_sig),
    .vsync_in(vsync_in), .int_req(int_req), .int_we(int_we),
    .int_address(int_address), .int_data_out(int_data_out),
    .int_ack(int_ack), .int_data_in(int_data_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } bus_t;

  bus_t        exp_q[$];
  logic [7:0]  hrd_exp_q[$];
  string       hrd_name_q[$];
  logic [7:0]  hrd_obs;
  event        hrd_ev;

  int          checks   = 0;
  int          failures = 0;
  bit          ack_en   = 1'b0;
  logic [15:0] read_data = 16'hBEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Internal-bus responder: acknowledges a request a couple of cycles late.
  initial begin
    int dly = 0;
    int_ack = 1'b0;
    int_data_in = 16'h0000;
    forever begin
      @(negedge clk);
      if (int_ack) int_ack = 1'b0;
      else if (int_req && ack_en) begin
        if (dly >= 1) begin
          int_ack = 1'b1;
          int_data_in = int_we ? 16'h0000 : read_data;
          dly = 0;
        end else dly++;
      end
    end
  end

  // Bus monitor: compares the request presented during each ack cycle.
  initial begin
    bus_t e;
    forever begin
      @(negedge clk);
      #2;
      if (int_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_unexpected: got addr 0x%0h we %0d expected no request",
                   int_address, int_we);
        end else begin
          e = exp_q.pop_front();
          check("bus_req", 32'(int_req), 32'd1);
          check("bus_we", 32'(int_we), 32'(e.we));
          check("bus_addr", 32'(int_address), 32'(e.addr));
          if (e.we) check("bus_wdata", 32'(int_data_out), 32'(e.data));
        end
      end
    end
  end

  // Host read monitor.
  initial begin
    forever begin
      @(hrd_ev);
      check(hrd_name_q.pop_front(), 32'(hrd_obs), 32'(hrd_exp_q.pop_front()));
    end
  end

  task automatic wait_clear();
    int n = 0;
    while (wait_sig && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_released", 32'(wait_sig), 32'd0);
  endtask

  task automatic host_write(input logic [3:0] sel, input logic [7:0] data, input bit stall);
    @(negedge clk);
    ext_address = sel;
    ext_data_in = data;
    ncs = 1'b0;
    nwr = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    if (stall) begin
      check("wait_on_full", 32'(wait_sig), 32'd1);
      ack_en = 1'b1;
    end
    wait_clear();
    @(negedge clk);
    ncs = 1'b1;
    nwr = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic host_read(input logic [3:0] sel, input logic [7:0] exp, input string name);
    hrd_exp_q.push_back(exp);
    hrd_name_q.push_back(name);
    @(negedge clk);
    ext_address = sel;
    ncs = 1'b0;
    nrd = 1'b0;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    wait_clear();
    @(negedge clk);
    hrd_obs = ext_data_out;
    ->hrd_ev;
    ncs = 1'b1;
    nrd = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || int_req) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    nrst = 1'b0;
    nrd = 1'b1; nwr = 1'b1; ncs = 1'b1;
    ext_address = '0; ext_data_in = '0; vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ext_data_out", 32'(ext_data_out), 32'h00);
    check("rst_wait_sig", 32'(wait_sig), 32'd0);
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_int_we", 32'(int_we), 32'd0);
    check("rst_int_sig", 32'(int_sig), 32'd0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    host_read(4'd5, 8'h01, "status_after_reset");

    // Single posted write with increment 1.
    ack_en = 1'b1;
    host_write(4'd0, 8'h00, 1'b0);
    host_write(4'd1, 8'h10, 1'b0);
    host_write(4'd4, 8'h10, 1'b0);
    host_write(4'd2, 8'h34, 1'b0);
    exp_q.push_back('{we: 1'b1, addr: 16'h1000, data: 16'h1234});
    host_write(4'd3, 8'h12, 1'b0);
    wait_drain();
    host_read(4'd5, 8'h09, "status_after_write");
    host_read(4'd0, 8'h01, "addr_lo_incr");
    host_read(4'd1, 8'h10, "addr_hi_incr");
    check("int_sig_masked", 32'(int_sig), 32'd0);
    host_write(4'd5, 8'h08, 1'b0);

    // Fill the FIFO with acks blocked, then one more write stalls.
    ack_en = 1'b0;
    host_write(4'd2, 8'h55, 1'b0);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      exp_q.push_back('{we: 1'b1, addr: 16'h1001 + 16'(i), data: {8'hA0 + 8'(i), 8'h55}});
      if (i == FIFO_DEPTH) host_read(4'd5, 8'h02, "status_full");
      host_write(4'd3, 8'hA0 + 8'(i), i == FIFO_DEPTH);
    end
    wait_drain();
    host_read(4'd0, 8'h0A, "addr_lo_after_burst");

    // Queued writes, ADDR rewritten while queued, then a read command.
    host_write(4'd5, 8'h08, 1'b0);
    ack_en = 1'b0;
    host_write(4'd4, 8'h00, 1'b0);
    host_write(4'd0, 8'h00, 1'b0);
    host_write(4'd1, 8'h30, 1'b0);
    host_write(4'd2, 8'hAA, 1'b0);
    exp_q.push_back('{we: 1'b1, addr: 16'h3000, data: 16'h01AA});
    host_write(4'd3, 8'h01, 1'b0);
    exp_q.push_back('{we: 1'b1, addr: 16'h3000, data: 16'h02AA});
    host_write(4'd3, 8'h02, 1'b0);
    host_write(4'd0, 8'h00, 1'b0);
    host_write(4'd1, 8'h20, 1'b0);
    host_write(4'd4, 8'h10, 1'b0);
    exp_q.push_back('{we: 1'b0, addr: 16'h2000, data: 16'h0000});
    host_write(4'd6, 8'h00, 1'b0);
    ack_en = 1'b1;
    host_read(4'd7, 8'hEF, "rdata_lo");
    host_read(4'd8, 8'hBE, "rdata_hi");
    wait_drain();
    host_read(4'd5, 8'h19, "status_read_valid");
    host_read(4'd0, 8'h01, "addr_lo_after_read");
    host_read(4'd1, 8'h20, "addr_hi_after_read");
    host_write(4'd5, 8'h0C, 1'b0);

    // vsync interrupt and set-beats-clear.
    host_write(4'd4, 8'h01, 1'b0);
    @(negedge clk); vsync_in = 1'b1;
    @(negedge clk); vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    check("int_sig_vsync", 32'(int_sig), 32'd1);
    fork
      host_write(4'd5, 8'h04, 1'b0);
      begin
        repeat (3) @(negedge clk);
        vsync_in = 1'b1;
        @(negedge clk);
        vsync_in = 1'b0;
      end
    join
    host_read(4'd5, 8'h15, "status_set_wins");
    check("int_sig_set_wins", 32'(int_sig), 32'd1);
    host_write(4'd5, 8'h04, 1'b0);
    check("int_sig_cleared", 32'(int_sig), 32'd0);
    host_read(4'd5, 8'h11, "status_cleared");

    // Reset in the middle of an outstanding write.
    ack_en = 1'b0;
    host_write(4'd4, 8'h00, 1'b0);
    host_write(4'd0, 8'h00, 1'b0);
    host_write(4'd1, 8'h40, 1'b0);
    host_write(4'd3, 8'h22, 1'b0);
    begin
      int n = 0;
      while (!int_req && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("req_before_reset", 32'(int_req), 32'd1);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("req_async_reset", 32'(int_req), 32'd0);
    check("ext_data_out_reset", 32'(ext_data_out), 32'h00);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    ack_en = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        seen |= int_req;
      end
      check("no_req_after_reset", 32'(seen), 32'd0);
    end
    host_read(4'd5, 8'h01, "status_after_midreset");

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
